permute_ctrl: RTL and testbench

Sequencing controller for the permute datapath. It walks the datapath through one full pass over NUM_SLICES 25-bit slices. For each slice it accepts one input line, applies the swap permutation PERMUTE_ROUNDS times in the working register, presents the result for write-out, and advances the datapath slice counter. It sits between the encoder top-level (start/done) and the permute datapath, and it generates every datapath control strobe.

---
 rtl/permute_ctrl.sv | 154 +++++++++++++++
 tb/tb_permute_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permute_ctrl.sv
// Sequencing controller for the permute datapath: walks one pass over NUM_SLICES
// slices (load, PERMUTE_ROUNDS swap passes, write-out, counter advance) and drives every strobe.
module permute_ctrl #(
    parameter int unsigned NUM_SLICES     = 64,
    parameter int unsigned PERMUTE_ROUNDS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       read_en,
    output logic       mux_en,
    output logic       reg_en,
    output logic       reg_rst,
    output logic       permute_en,
    output logic       write_en,
    output logic       cnt_64_en,
    output logic [5:0] slice_idx
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned RND_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(PERMUTE_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_PERM,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic in_ready;
        logic mux_en;
        logic reg_en_perm;
        logic reg_rst;
        logic permute_en;
        logic write_en;
        logic cnt_en;
        logic done;
    } moore_t;

    state_t             r_state;
    state_t             w_next;
    moore_t             r_moore;
    logic [RND_W-1:0]   r_round;
    logic [IDX_W-1:0]   r_slice_idx;
    logic               w_load_fire;
    logic               w_last_slice;

    // Moore output decode; registered from the next state so outputs track the state register.
    function automatic moore_t f_decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_IDLE:  m = '0;
            S_CLEAR: begin
                m.busy    = 1'b1;
                m.reg_rst = 1'b1;
            end
            S_LOAD: begin
                m.busy     = 1'b1;
                m.in_ready = 1'b1;
            end
            S_PERM: begin
                m.busy        = 1'b1;
                m.mux_en      = 1'b1;
                m.reg_en_perm = 1'b1;
                m.permute_en  = 1'b1;
            end
            S_WRITE: begin
                m.busy     = 1'b1;
                m.write_en = 1'b1;
            end
            S_NEXT: begin
                m.busy   = 1'b1;
                m.cnt_en = 1'b1;
            end
            S_DONE: begin
                m.busy = 1'b1;
                m.done = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    assign w_load_fire  = (r_state == S_LOAD) && in_valid;
    assign w_last_slice = (r_slice_idx == LAST_IDX);

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLEAR;
            S_CLEAR: w_next = S_LOAD;
            S_LOAD:  if (in_valid) w_next = S_PERM;
            S_PERM:  if (r_round == LAST_RND) w_next = S_WRITE;
            S_WRITE: if (out_ready) w_next = S_NEXT;
            S_NEXT:  w_next = w_last_slice ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, registered outputs, round and slice counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_moore     <= '0;
            r_round     <= '0;
            r_slice_idx <= '0;
        end else begin
            r_state <= w_next;
            r_moore <= f_decode(w_next);

            if (w_load_fire) begin
                r_round <= '0;
            end else if (r_state == S_PERM) begin
                r_round <= r_round + RND_W'(1);
            end

            case (r_state)
                S_CLEAR: r_slice_idx <= '0;
                S_NEXT:  if (!w_last_slice) r_slice_idx <= r_slice_idx + IDX_W'(1);
                S_DONE:  r_slice_idx <= '0;
                default: r_slice_idx <= r_slice_idx;
            endcase
        end
    end

    // read_en / reg_en in LOAD are the only outputs qualified by an input.
    assign read_en    = r_moore.in_ready & in_valid;
    assign reg_en     = r_moore.reg_en_perm | read_en;
    assign busy       = r_moore.busy;
    assign done       = r_moore.done;
    assign in_ready   = r_moore.in_ready;
    assign mux_en     = r_moore.mux_en;
    assign reg_rst    = r_moore.reg_rst;
    assign permute_en = r_moore.permute_en;
    assign write_en   = r_moore.write_en;
    assign cnt_64_en  = r_moore.cnt_en;
    assign slice_idx  = r_slice_idx;

endmodule

// File: tb/tb_permute_ctrl.sv
// Scoreboard bench for permute_ctrl: default instance (64 slices, 1 round) plus a
// 4-slice / 3-round instance; expected events are queued at stimulus time.
module tb_permute_ctrl;

    localparam int N  = 64;
    localparam int R  = 1;
    localparam int SN = 4;
    localparam int SR = 3;

    typedef struct {
        int slice;
        int cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic       busy, done, in_ready, read_en, mux_en, reg_en, reg_rst;
    logic       permute_en, write_en, cnt_64_en;
    logic [5:0] slice_idx;

    logic       s_rst, s_start, s_in_valid, s_out_ready;
    logic       s_busy, s_done, s_in_ready, s_read_en, s_mux_en, s_reg_en, s_reg_rst;
    logic       s_permute_en, s_write_en, s_cnt_64_en;
    logic [5:0] s_slice_idx;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  viol = 0;
    int  pass_cnt = 0;
    int  pass_rd = 0;
    bit  rst_prev = 1'b0;
    bit  stall_en = 1'b0;
    bit  rst_mid_en = 1'b0;
    int  in_left = 0;
    int  out_left = 0;

    wr_t exp_wr_q[$];
    int  exp_done_q[$];
    int  exp_rst_q[$];
    wr_t s_exp_wr_q[$];
    int  s_exp_done_q[$];

    permute_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .read_en(read_en), .mux_en(mux_en), .reg_en(reg_en), .reg_rst(reg_rst),
        .permute_en(permute_en), .write_en(write_en), .cnt_64_en(cnt_64_en),
        .slice_idx(slice_idx)
    );

    permute_ctrl #(.NUM_SLICES(SN), .PERMUTE_ROUNDS(SR)) u_dut_small (
        .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_ready(s_out_ready),
        .read_en(s_read_en), .mux_en(s_mux_en), .reg_en(s_reg_en), .reg_rst(s_reg_rst),
        .permute_en(s_permute_en), .write_en(s_write_en), .cnt_64_en(s_cnt_64_en),
        .slice_idx(s_slice_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    // Queue the expected events of one pass started (start sampled) in cycle t0.
    task automatic push_pass(input int t0, input int nwr, input bit complete,
                             input int sin_slice, input int sin,
                             input int sout_slice, input int sout);
        wr_t w;
        int  sh;
        exp_rst_q.push_back(t0 + 1);
        for (int s = 0; s < nwr; s++) begin
            sh = ((s >= sin_slice) ? sin : 0) + ((s >= sout_slice) ? sout : 0);
            w.slice = s;
            w.cyc   = t0 + 2 + s * (R + 3) + 1 + R + sh;
            exp_wr_q.push_back(w);
        end
        if (complete) exp_done_q.push_back(t0 + 2 + N * (R + 3) + sin + sout);
    endtask

    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Input driver for stall and mid-pass reset scenarios (acts just after the edge).
    always begin
        @(posedge clk);
        #1;
        if (stall_en) begin
            if (in_ready && slice_idx == 6'd10 && in_left > 0) begin
                in_valid = 1'b0;
                in_left--;
            end else begin
                in_valid = 1'b1;
            end
            if (write_en && slice_idx == 6'd20 && out_left > 0) begin
                out_ready = 1'b0;
                out_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
        if (rst_mid_en && write_en && slice_idx == 6'd30) begin
            rst        = 1'b1;
            out_ready  = 1'b0;
            rst_mid_en = 1'b0;
        end
    end

    // Monitor for the default instance.
    always @(negedge clk) begin
        static bit done_prev = 1'b0;
        wr_t       w;
        int        e;
        int        nstr;

        if (rst_prev) begin
            n_cmp++;
            if ({busy, done, in_ready, read_en, mux_en, reg_en, reg_rst, permute_en,
                 write_en, cnt_64_en} != 10'd0 || slice_idx != 6'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got busy=%b done=%b strobes=%b idx=%0d want all 0",
                         cyc, busy, done, {in_ready, read_en, mux_en, reg_en, reg_rst,
                         permute_en, write_en, cnt_64_en}, slice_idx);
            end
        end
        if (done_prev) begin
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_after_done cyc=%0d got %b want 0", cyc, busy);
            end
        end
        done_prev = done;

        nstr = int'(reg_rst) + int'(read_en) + int'(permute_en) + int'(write_en) + int'(cnt_64_en);
        if (nstr > 1) viol++;
        if (write_en && reg_en) viol++;
        if (in_ready && !in_valid && (read_en || reg_en)) viol++;
        if (int'(slice_idx) >= N) viol++;

        if (cnt_64_en) pass_cnt++;
        if (read_en) pass_rd++;

        if (reg_rst) begin
            n_cmp++;
            if (exp_rst_q.size() == 0) begin
                n_fail++;
                $display("FAIL clear_unexpected cyc=%0d got reg_rst want none", cyc);
            end else begin
                e = exp_rst_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL clear_cycle got %0d want %0d", cyc, e);
                end
            end
            pass_cnt = 0;
            pass_rd  = 0;
        end

        if (write_en && out_ready) begin
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected cyc=%0d slice=%0d want none", cyc, slice_idx);
            end else begin
                w = exp_wr_q.pop_front();
                if (w.cyc != cyc || w.slice != int'(slice_idx)) begin
                    n_fail++;
                    $display("FAIL write got slice %0d at %0d want slice %0d at %0d",
                             slice_idx, cyc, w.slice, w.cyc);
                end
            end
        end

        if (done) begin
            n_cmp++;
            if (exp_done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected cyc=%0d want none", cyc);
            end else begin
                e = exp_done_q.pop_front();
                if (e != cyc || pass_cnt != N || pass_rd != N) begin
                    n_fail++;
                    $display("FAIL done got cyc %0d cnt %0d rd %0d want cyc %0d cnt %0d rd %0d",
                             cyc, pass_cnt, pass_rd, e, N, N);
                end
            end
        end
    end

    // Monitor for the 4-slice / 3-round instance.
    always @(negedge clk) begin
        static int run = 0;
        wr_t       w;
        int        e;

        if (s_permute_en) begin
            run++;
        end else if (run > 0) begin
            n_cmp++;
            if (run != SR) begin
                n_fail++;
                $display("FAIL small_perm_run got %0d want %0d", run, SR);
            end
            run = 0;
        end

        if (s_write_en && s_out_ready) begin
            n_cmp++;
            if (s_exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL small_write_unexpected cyc=%0d want none", cyc);
            end else begin
                w = s_exp_wr_q.pop_front();
                if (w.cyc != cyc || w.slice != int'(s_slice_idx)) begin
                    n_fail++;
                    $display("FAIL small_write got slice %0d at %0d want slice %0d at %0d",
                             s_slice_idx, cyc, w.slice, w.cyc);
                end
            end
        end

        if (s_done) begin
            n_cmp++;
            if (s_exp_done_q.size() == 0) begin
                n_fail++;
                $display("FAIL small_done_unexpected cyc=%0d want none", cyc);
            end else begin
                e = s_exp_done_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL small_done got %0d want %0d", cyc, e);
                end
            end
        end
    end

    // Small-instance stimulus.
    initial begin
        int  st0;
        wr_t w;
        s_rst       = 1'b1;
        s_start     = 1'b0;
        s_in_valid  = 1'b1;
        s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_rst   = 1'b0;
        s_start = 1'b1;
        st0     = cyc;
        for (int s = 0; s < SN; s++) begin
            w.slice = s;
            w.cyc   = st0 + 2 + s * (SR + 3) + 1 + SR;
            s_exp_wr_q.push_back(w);
        end
        s_exp_done_q.push_back(st0 + 2 + SN * (SR + 3));
        @(posedge clk);
        #1;
        s_start = 1'b0;
    end

    // Main stimulus sequence.
    initial begin
        int  t0, t1, t2, t3;
        bit  hit;
        rst       = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pass 1: nominal, start taken right after reset, stray start mid-pass.
        rst = 1'b0;
        t0  = cyc;
        push_pass(t0, N, 1'b1, 1000, 0, 1000, 0);
        go_to(t0 + 1);
        start = 1'b0;
        go_to(t0 + 50);
        start = 1'b1;
        go_to(t0 + 51);
        start = 1'b0;

        // Pass 2: start held through DONE; stalls on slices 10 (input) and 20 (output).
        go_to(t0 + 255);
        start    = 1'b1;
        t1       = t0 + 259;
        in_left  = 5;
        out_left = 7;
        stall_en = 1'b1;
        push_pass(t1, N, 1'b1, 10, 5, 20, 7);
        go_to(t1 + 1);
        start = 1'b0;
        go_to(t1 + 2 + N * (R + 3) + 12 + 3);
        stall_en  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;

        // Pass 3: reset while slice 30 sits in WRITE.
        start = 1'b1;
        t2    = cyc;
        push_pass(t2, 30, 1'b0, 1000, 0, 1000, 0);
        rst_mid_en = 1'b1;
        go_to(t2 + 1);
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(posedge clk);
            #2;
            hit = (rst == 1'b1);
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_reset_trigger got no WRITE of slice 30 want one");
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (pass_cnt != 30) begin
            n_fail++;
            $display("FAIL mid_reset_cnt got %0d want 30", pass_cnt);
        end

        // Pass 4: full pass after the aborted one.
        go_to(cyc + 3);
        start = 1'b1;
        t3    = cyc;
        push_pass(t3, N, 1'b1, 1000, 0, 1000, 0);
        go_to(t3 + 1);
        start = 1'b0;
        go_to(t3 + 2 + N * (R + 3) + 4);

        n_cmp++;
        if (exp_wr_q.size() != 0 || exp_done_q.size() != 0 || exp_rst_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got wr=%0d done=%0d clr=%0d pending want 0",
                     exp_wr_q.size(), exp_done_q.size(), exp_rst_q.size());
        end
        n_cmp++;
        if (s_exp_wr_q.size() != 0 || s_exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL small_leftover got wr=%0d done=%0d pending want 0",
                     s_exp_wr_q.size(), s_exp_done_q.size());
        end
        n_cmp++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL strobe_exclusive got %0d violations want 0", viol);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
